launch_countdown: RTL
=====================

Name: launch_countdown

Overview:
- Launch sequencer, directly downstream of the button edge detector.
- Consumes single-cycle start and abort pulses and runs a seconds-resolution BCD countdown from COUNT_START to 0.
- At zero, asserts the launch output for a fixed hold time, then returns to idle.
- The BCD count feeds the seven-segment display driver; launch/aborted drive the status LEDs.

Parameters:
- TICKS_PER_SEC, 12000000, clk cycles per countdown second (12 MHz board clock); legal range 2..2^24.
- COUNT_START, 10, countdown start value in seconds; legal range 1..99.
- LAUNCH_HOLD_S, 3, seconds launch stays high after reaching zero; legal range 1..15.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start_pulse  input  1  one-cycle rising-edge pulse from the start button edge detector.
- abort_pulse  input  1  one-cycle rising-edge pulse from the abort button edge detector.
- count_bcd  output  8  current count, tens digit [7:4], ones digit [3:0].
- counting  output  1  high while in COUNTING.
- launch  output  1  high while in LAUNCH.
- aborted  output  1  high while in ABORTED.

Behaviour:
- All outputs are registered or decoded directly from the state register. There is no combinational path from inputs to outputs.
- Reset (async, rst=1): state=IDLE, prescaler=0, hold counter=0, count_bcd=BCD(COUNT_START), counting=0, launch=0, aborted=0.
- Prescaler:
  - Counts 0..TICKS_PER_SEC-1.
  - sec_tick is internal and asserted when prescaler==TICKS_PER_SEC-1; the prescaler wraps to 0 on that edge.
  - The prescaler runs only in COUNTING and LAUNCH, and is cleared to 0 on every state transition.
- States and transitions:
  - IDLE:
    - count_bcd holds BCD(COUNT_START).
    - start_pulse=1 and abort_pulse=0 -> COUNTING on the next edge.
    - abort_pulse alone: no effect.
  - COUNTING:
    - abort_pulse=1 -> ABORTED. Abort has priority over a same-cycle sec_tick; count_bcd is frozen at its pre-tick value.
    - Otherwise, on sec_tick, count_bcd decrements by 1 in BCD. If ones==0: ones<=9, tens<=tens-1.
    - If count_bcd==01 on sec_tick: count_bcd<=00 and state -> LAUNCH on the same edge.
    - start_pulse is ignored (no restart).
  - LAUNCH:
    - count_bcd=00.
    - Hold counter increments on each sec_tick. When it reaches LAUNCH_HOLD_S: state -> IDLE, count_bcd reloads BCD(COUNT_START), hold counter cleared.
    - start_pulse and abort_pulse are both ignored (no abort after ignition).
  - ABORTED:
    - count_bcd frozen.
    - start_pulse -> IDLE with count_bcd reloaded. A further start_pulse is needed to count again.
    - abort_pulse ignored.
- Output decode: counting/launch/aborted are one-hot with respect to COUNTING/LAUNCH/ABORTED; all are 0 in IDLE.
- Timing:
  - The first decrement occurs exactly TICKS_PER_SEC edges after the edge that samples start_pulse.
  - Subsequent decrements occur every TICKS_PER_SEC edges.
  - launch stays high for exactly LAUNCH_HOLD_S*TICKS_PER_SEC cycles.
- Simultaneous start_pulse and abort_pulse in IDLE: remain in IDLE.
- Reset mid-operation (any state): immediate return to reset values without waiting for a clock edge; no partial launch pulse survives.
- Inputs are already synchronous to clk; no internal synchronizers.
- Illegal state encodings recover to IDLE on the next edge.

Test Plan:
- Bench parameters for all scenarios: TICKS_PER_SEC=4, COUNT_START=3, LAUNCH_HOLD_S=2.
- Reset then idle 20 cycles -> count_bcd=0x03, counting=launch=aborted=0; abort_pulse during idle has no effect.
- start_pulse at edge N:
  - counting=1 from N.
  - count_bcd=0x02 after edge N+4, 0x01 after N+8.
  - 0x00 with launch=1 after N+12.
  - launch=0, count_bcd=0x03, IDLE after N+20.
- Count from COUNT_START=12 (separate run) -> sequence 0x12, 0x11, 0x10, 0x09, 0x08, verifying the BCD borrow across the tens digit.
- start, then abort_pulse on the same cycle as the second sec_tick:
  - aborted=1, count_bcd stays 0x02.
  - A later start_pulse -> IDLE with 0x03.
  - A second start_pulse restarts counting.
- During LAUNCH, pulse abort_pulse and start_pulse -> launch remains high for the full 8 cycles; no state change.
- Assert rst asynchronously (between edges) mid-COUNTING and mid-LAUNCH -> outputs reach reset values before the next clk edge; after release, start_pulse runs a full clean countdown.

Source files
------------

// File: rtl/launch_countdown.sv
// Launch sequencer: BCD seconds countdown from COUNT_START to zero, then a
// timed launch hold, with abort and restart handling. Fed by the button
// edge detectors; drives the seven-segment driver and status LEDs.
module launch_countdown #(
    parameter int TICKS_PER_SEC = 12000000,
    parameter int COUNT_START   = 10,
    parameter int LAUNCH_HOLD_S = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_pulse,
    input  logic       abort_pulse,
    output logic [7:0] count_bcd,
    output logic       counting,
    output logic       launch,
    output logic       aborted
);

    localparam int              PS_W      = $clog2(TICKS_PER_SEC);
    localparam logic [PS_W-1:0] PS_LAST   = PS_W'(TICKS_PER_SEC - 1);
    localparam logic [7:0]      START_BCD = {4'(COUNT_START / 10), 4'(COUNT_START % 10)};
    localparam logic [3:0]      HOLD_LAST = 4'(LAUNCH_HOLD_S - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COUNTING = 2'd1,
        S_LAUNCH   = 2'd2,
        S_ABORTED  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PS_W-1:0] ps_q, ps_d;
    logic [3:0]      hold_q, hold_d;
    logic [7:0]      count_q, count_d;
    logic            sec_tick;

    // One-step BCD decrement with borrow from the tens digit.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        else
            return {v[7:4], v[3:0] - 4'd1};
    endfunction

    assign sec_tick = (ps_q == PS_LAST);

    // Next-state, count, hold and prescaler decisions.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        hold_d  = hold_q;
        ps_d    = '0;
        case (state_q)
            S_IDLE: begin
                count_d = START_BCD;
                hold_d  = 4'd0;
                if (start_pulse && !abort_pulse)
                    state_d = S_COUNTING;
            end
            S_COUNTING: begin
                ps_d = sec_tick ? '0 : ps_q + PS_W'(1);
                if (abort_pulse) begin
                    // abort wins over a same-cycle tick; count stays put
                    state_d = S_ABORTED;
                end else if (sec_tick) begin
                    count_d = bcd_dec(count_q);
                    if (count_q == 8'h01)
                        state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                ps_d    = sec_tick ? '0 : ps_q + PS_W'(1);
                count_d = 8'h00;
                if (sec_tick) begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = S_IDLE;
                        count_d = START_BCD;
                        hold_d  = 4'd0;
                    end else begin
                        hold_d = hold_q + 4'd1;
                    end
                end
            end
            S_ABORTED: begin
                if (start_pulse) begin
                    state_d = S_IDLE;
                    count_d = START_BCD;
                end
            end
            default: begin
                state_d = S_IDLE;
                count_d = START_BCD;
                hold_d  = 4'd0;
            end
        endcase
        // every transition restarts the second boundary from zero
        if (state_d != state_q)
            ps_d = '0;
    end

    // State, count and timer registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ps_q    <= '0;
            hold_q  <= 4'd0;
            count_q <= START_BCD;
        end else begin
            state_q <= state_d;
            ps_q    <= ps_d;
            hold_q  <= hold_d;
            count_q <= count_d;
        end
    end

    assign count_bcd = count_q;
    assign counting  = (state_q == S_COUNTING);
    assign launch    = (state_q == S_LAUNCH);
    assign aborted   = (state_q == S_ABORTED);

endmodule
